// File: rtl/cs_stat_tx.sv
// Status-reply packer: snapshots the device descriptor and length fields on a start
// handshake and writes a 12-byte status frame, with running checksum, into the TX FIFO.
module cs_stat_tx #(
  parameter logic [7:0] HEAD0 = 8'h55,
  parameter logic [7:0] HEAD1 = 8'hAA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fs,
  output logic        fd,
  input  logic [7:0]  dev_info,
  input  logic [7:0]  dev_kind,
  input  logic [7:0]  dev_smpr,
  input  logic [7:0]  cmd_kdev,
  input  logic [11:0] eth_tx_len,
  input  logic [9:0]  adc_rx_len,
  input  logic        fifo_full,
  output logic [7:0]  fifo_txd,
  output logic        fifo_txen,
  output logic [7:0]  seq
);

  typedef enum logic [1:0] {StIdle, StLoad, StSend, StDone} state_e;

  localparam logic [3:0] LastIdx = 4'd11;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  csum_q, csum_d;
  logic [7:0]  seq_q, seq_d;
  logic        fd_q, fd_d;
  logic        txen_q, txen_d;
  logic [7:0]  txd_q, txd_d;

  // Frame fields captured in LOAD
  logic [7:0]  info_q, info_d;
  logic [7:0]  kind_q, kind_d;
  logic [7:0]  smpr_q, smpr_d;
  logic [7:0]  kdev_q, kdev_d;
  logic [11:0] eth_len_q, eth_len_d;
  logic [9:0]  adc_len_q, adc_len_d;
  logic [7:0]  seq_snap_q, seq_snap_d;

  logic [7:0]  cur_byte;
  logic        in_csum;

  always_comb begin
    cur_byte = 8'h00;
    case (idx_q)
      4'd0:    cur_byte = HEAD0;
      4'd1:    cur_byte = HEAD1;
      4'd2:    cur_byte = info_q;
      4'd3:    cur_byte = kind_q;
      4'd4:    cur_byte = smpr_q;
      4'd5:    cur_byte = kdev_q;
      4'd6:    cur_byte = {4'h0, eth_len_q[11:8]};
      4'd7:    cur_byte = eth_len_q[7:0];
      4'd8:    cur_byte = {6'h0, adc_len_q[9:8]};
      4'd9:    cur_byte = adc_len_q[7:0];
      4'd10:   cur_byte = seq_snap_q;
      4'd11:   cur_byte = csum_q;
      default: cur_byte = 8'h00;
    endcase
  end

  // Checksum covers payload bytes 2..10 only
  assign in_csum = (idx_q >= 4'd2) && (idx_q <= 4'd10);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    csum_d     = csum_q;
    seq_d      = seq_q;
    txen_d     = 1'b0;
    txd_d      = txd_q;
    info_d     = info_q;
    kind_d     = kind_q;
    smpr_d     = smpr_q;
    kdev_d     = kdev_q;
    eth_len_d  = eth_len_q;
    adc_len_d  = adc_len_q;
    seq_snap_d = seq_snap_q;
    // Done pulses once if fs is already low; otherwise held until fs drops
    fd_d       = (state_q == StDone) && (fs || !fd_q);

    case (state_q)
      StIdle: begin
        idx_d = 4'd0;
        if (fs) state_d = StLoad;
      end
      StLoad: begin
        info_d     = dev_info;
        kind_d     = dev_kind;
        smpr_d     = dev_smpr;
        kdev_d     = cmd_kdev;
        eth_len_d  = eth_tx_len;
        adc_len_d  = adc_rx_len;
        seq_snap_d = seq_q;
        csum_d     = 8'h00;
        idx_d      = 4'd0;
        state_d    = StSend;
      end
      StSend: begin
        if (!fifo_full) begin
          txen_d = 1'b1;
          txd_d  = cur_byte;
          if (in_csum) csum_d = csum_q + cur_byte;
          if (idx_q == LastIdx) begin
            idx_d   = 4'd0;
            seq_d   = seq_q + 8'd1;
            state_d = StDone;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      StDone: begin
        if (!fs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      idx_q      <= 4'd0;
      csum_q     <= 8'h00;
      seq_q      <= 8'h00;
      fd_q       <= 1'b0;
      txen_q     <= 1'b0;
      txd_q      <= 8'h00;
      info_q     <= 8'h00;
      kind_q     <= 8'h00;
      smpr_q     <= 8'h00;
      kdev_q     <= 8'h00;
      eth_len_q  <= 12'h000;
      adc_len_q  <= 10'h000;
      seq_snap_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      csum_q     <= csum_d;
      seq_q      <= seq_d;
      fd_q       <= fd_d;
      txen_q     <= txen_d;
      txd_q      <= txd_d;
      info_q     <= info_d;
      kind_q     <= kind_d;
      smpr_q     <= smpr_d;
      kdev_q     <= kdev_d;
      eth_len_q  <= eth_len_d;
      adc_len_q  <= adc_len_d;
      seq_snap_q <= seq_snap_d;
    end
  end

  assign fd        = fd_q;
  assign fifo_txen = txen_q;
  assign fifo_txd  = txd_q;
  assign seq       = seq_q;

endmodule

// File: tb/tb_cs_stat_tx.sv
// Scoreboard bench for cs_stat_tx: expected frames are built from field values and
// queued at stimulus time; a monitor pops and compares each FIFO write.
module tb_cs_stat_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fs = 1'b0;
  logic        fd;
  logic [7:0]  dev_info, dev_kind, dev_smpr, cmd_kdev;
  logic [11:0] eth_tx_len;
  logic [9:0]  adc_rx_len;
  logic        fifo_full = 1'b0;
  logic [7:0]  fifo_txd;
  logic        fifo_txen;
  logic [7:0]  seq;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_seq = 8'h00;

  cs_stat_tx dut (
    .clk        (clk),
    .rst        (rst),
    .fs         (fs),
    .fd         (fd),
    .dev_info   (dev_info),
    .dev_kind   (dev_kind),
    .dev_smpr   (dev_smpr),
    .cmd_kdev   (cmd_kdev),
    .eth_tx_len (eth_tx_len),
    .adc_rx_len (adc_rx_len),
    .fifo_full  (fifo_full),
    .fifo_txd   (fifo_txd),
    .fifo_txen  (fifo_txen),
    .seq        (seq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame: header, fields, sequence, then mod-256 sum of bytes 2..10
  task automatic push_frame(input logic [7:0] sq);
    logic [7:0] f[12];
    logic [7:0] sum;
    f[0]  = 8'h55;
    f[1]  = 8'hAA;
    f[2]  = dev_info;
    f[3]  = dev_kind;
    f[4]  = dev_smpr;
    f[5]  = cmd_kdev;
    f[6]  = 8'(eth_tx_len >> 8);
    f[7]  = eth_tx_len[7:0];
    f[8]  = 8'(adc_rx_len >> 8);
    f[9]  = adc_rx_len[7:0];
    f[10] = sq;
    sum = 8'h00;
    for (int i = 2; i <= 10; i++) sum = sum + f[i];
    f[11] = sum;
    for (int i = 0; i < 12; i++) exp_q.push_back(f[i]);
  endtask

  always @(negedge clk) begin
    if (rst && fifo_txen) begin
      if (exp_q.size() == 0) begin
        check("unexpected_byte", {24'h0, fifo_txd}, 32'hFFFF_FFFF);
      end else begin
        check("fifo_byte", {24'h0, fifo_txd}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic set_fields(input logic [7:0] i, input logic [7:0] k, input logic [7:0] s,
                            input logic [7:0] d, input logic [11:0] e, input logic [9:0] a);
    dev_info = i; dev_kind = k; dev_smpr = s; cmd_kdev = d; eth_tx_len = e; adc_rx_len = a;
  endtask

  // mask bit c = fifo_full before edge N+c (fs sampled at edge N)
  task automatic run_frame(input logic [63:0] mask, input int snap_c, input int drop_c,
                           input int hold);
    int lat;
    int exp_lat;
    int written;
    push_frame(model_seq);
    written = 0;
    exp_lat = 2;
    while (written < 12) begin
      if (!mask[exp_lat]) written++;
      exp_lat++;
    end
    @(negedge clk);
    fs = 1'b1;
    lat = -1;
    for (int c = 0; c < 100 && lat < 0; c++) begin
      fifo_full = (c < 64) ? mask[c] : 1'b0;
      if (c == snap_c) set_fields(8'hFF, 8'hFF, 8'hFF, 8'hFF, 12'hFFF, 10'h3FF);
      if (c == drop_c) fs = 1'b0;
      @(negedge clk);
      if (fd) lat = c;
    end
    fifo_full = 1'b0;
    check("fd_latency", lat, exp_lat);
    model_seq = model_seq + 8'd1;
    check("seq_after", {24'h0, seq}, {24'h0, model_seq});
    if (lat >= 0) begin
      if (fs) begin
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          check("fd_held", {31'h0, fd}, 32'h1);
        end
        fs = 1'b0;
        @(negedge clk);
        check("fd_fall", {31'h0, fd}, 32'h0);
      end else begin
        @(negedge clk);
        check("fd_pulse_end", {31'h0, fd}, 32'h0);
      end
    end
    fs = 1'b0;
    check("sb_drained", exp_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    set_fields(8'h12, 8'h34, 8'h56, 8'h78, 12'h3A4, 10'h2C0);
    repeat (3) @(negedge clk);
    check("rst_fd", {31'h0, fd}, 32'h0);
    check("rst_txen", {31'h0, fifo_txen}, 32'h0);
    check("rst_txd", {24'h0, fifo_txd}, 32'h0);
    check("rst_seq", {24'h0, seq}, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Basic frame: 55 AA 12 34 56 78 03 A4 02 C0 00 7D
    run_frame(64'h0, -1, -1, 2);

    // Backpressure: 3 stalls at byte 4, 1 at byte 11
    set_fields(8'h12, 8'h34, 8'h56, 8'h78, 12'h3A4, 10'h2C0);
    run_frame((64'h7 << 6) | (64'h1 << 16), -1, -1, 1);

    // Snapshot: inputs forced to FF after LOAD
    set_fields(8'h01, 8'h9C, 8'h3E, 8'hD2, 12'h5B7, 10'h1E9);
    run_frame(64'h0, 2, -1, 1);

    // Early fs drop at byte 5
    set_fields(8'hA5, 8'h5A, 8'hC3, 8'h3C, 12'hF0F, 10'h155);
    run_frame(64'h0, -1, 7, 0);

    // Reset mid-frame during byte 7
    set_fields(8'h11, 8'h22, 8'h33, 8'h44, 12'h555, 10'h266);
    push_frame(model_seq);
    @(negedge clk);
    fs = 1'b1;
    repeat (10) @(negedge clk);
    check("byte7_txen", {31'h0, fifo_txen}, 32'h1);
    #2 rst = 1'b0;
    #1;
    check("async_txen", {31'h0, fifo_txen}, 32'h0);
    check("async_seq", {24'h0, seq}, 32'h0);
    check("async_fd", {31'h0, fd}, 32'h0);
    fs = 1'b0;
    exp_q.delete();
    model_seq = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    set_fields(8'h12, 8'h34, 8'h56, 8'h78, 12'h3A4, 10'h2C0);
    run_frame(64'h0, -1, -1, 1);

    // Sequence wrap over 256 frames from seq 0, random data and sparse stalls
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_seq = 8'h00;
    @(negedge clk);
    for (int n = 0; n < 256; n++) begin
      logic [63:0] m;
      set_fields(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                 12'($urandom), 10'($urandom));
      m = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      m[63:40] = '0;
      run_frame(m, -1, -1, 3);
    end
    check("seq_wrapped", {24'h0, seq}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cs_stat_tx.md
# cs_stat_tx

Status-reply packer for the control/status path: the transmit-side counterpart of the command decoder in `cs`. On a start handshake it snapshots the device descriptor and length fields that `cs` produces. It serializes them into a fixed 12-byte status frame, writes the frame byte-by-byte into the command-side TX FIFO, and then signals done. The frame is later drained toward the UDP transmitter.

## Interface
Parameters:
- `HEAD0`, 8'h55, first frame header byte
- `HEAD1`, 8'hAA, second frame header byte

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `fs`  in  1  start request; level, held high by requester until `fd` seen
- `fd`  out  1  done; level, held until `fs` low
- `dev_info`  in  8  device info byte
- `dev_kind`  in  8  device kind byte
- `dev_smpr`  in  8  sample-rate byte
- `cmd_kdev`  in  8  last received kdev command, echoed back
- `eth_tx_len`  in  12  Ethernet TX payload length
- `adc_rx_len`  in  10  ADC RX length
- `fifo_full`  in  1  TX FIFO full
- `fifo_txd`  out  8  byte to FIFO
- `fifo_txen`  out  1  FIFO write strobe; one byte per high cycle
- `seq`  out  8  sequence number of the next frame

## Operation
- States: IDLE, LOAD, SEND, DONE.
  - IDLE→LOAD when `fs`=1.
  - LOAD→SEND unconditionally.
  - SEND→DONE after byte 11 is written.
  - DONE→IDLE when `fs`=0.
- LOAD snapshots all inputs, plus `seq`, into internal registers. Input changes after LOAD do not affect the current frame.
- Frame byte order (index 0..11):
  - 0: `HEAD0`
  - 1: `HEAD1`
  - 2: `dev_info`
  - 3: `dev_kind`
  - 4: `dev_smpr`
  - 5: `cmd_kdev`
  - 6: {4'h0, `eth_tx_len[11:8]`}
  - 7: `eth_tx_len[7:0]`
  - 8: {6'h0, `adc_rx_len[9:8]`}
  - 9: `adc_rx_len[7:0]`
  - 10: `seq`
  - 11: checksum
- Checksum: 8-bit sum of bytes 2..10, modulo 256; carries are discarded. It is accumulated as bytes are written.
- SEND writes:
  - When `fifo_full`=0: `fifo_txen`=1, `fifo_txd`=current byte, and the byte index increments.
  - When `fifo_full`=1: `fifo_txen`=0 and the index holds. There is no byte loss and no duplication.
- `seq` increments by 1 on the transition SEND→DONE, wrapping 8'hFF→8'h00.
- `fs` dropping during LOAD or SEND is ignored; the frame always completes. If `fs` is already 0 on entry to DONE, `fd` is high for exactly one cycle.
- `fs` must return low before a new frame starts. A `fs` still high in DONE never retriggers.

## Timing
- Reset (async assert, sync release) sets:
  - state=IDLE
  - `fd`=0, `fifo_txen`=0, `fifo_txd`=8'h00, `seq`=8'h00
  - byte index=0, checksum=0
- Reset mid-frame abandons the frame immediately. No further writes occur; bytes already written stay in the FIFO.
- `fs` sampled high at edge N gives LOAD at N+1. The first `fifo_txen` (byte 0) is registered at edge N+2.
- With `fifo_full`=0 throughout:
  - bytes 0..11 are on 12 consecutive cycles;
  - `fd` rises on the edge after byte 11, i.e. 14 cycles after `fs` is sampled.
- Each full cycle during SEND adds exactly one cycle of latency.
- `fifo_txd` and `fifo_txen` are registered and change together. `fifo_txd` holds its last value when `fifo_txen`=0.
- After `fs` is sampled low in DONE, `fd` falls on the next edge; a new `fs` is accepted one cycle later from IDLE.

## Test plan
- **Basic frame.** After reset, set `dev_info`=12, `dev_kind`=34, `dev_smpr`=56, `cmd_kdev`=78, `eth_tx_len`=3A4, `adc_rx_len`=2C0, then pulse `fs` high until `fd`.
  - Required: FIFO receives 55 AA 12 34 56 78 03 A4 02 C0 00 7D on 12 consecutive cycles.
  - Required: `fd` high 14 cycles after `fs`; `seq`=01 afterwards.
- **Backpressure.** Repeat with `fifo_full`=1 for 3 cycles when byte 4 is due, and for 1 cycle at byte 11.
  - Required: identical byte stream with no gaps in content; `fd` delayed by exactly 4 cycles.
- **Snapshot.** Change all data inputs to FF on the cycle after LOAD.
  - Required: frame still carries the values captured at LOAD; checksum matches the captured values.
- **Sequence wrap and handshake.** Run 256 frames, holding `fs` high 3 cycles past `fd` each time.
  - Required: frame 256 has byte 10 = FF; `seq` then reads 00; no retrigger while `fs` is held; `fd` falls 1 cycle after `fs` drops.
- **Early `fs` drop.** Drop `fs` during SEND at byte 5.
  - Required: all 12 bytes are still written; `fd` is high for exactly 1 cycle.
- **Reset mid-frame.** Assert `rst` low during byte 7.
  - Required: `fifo_txen` goes to 0 immediately (async); `seq`=00; the next `fs` produces a full frame starting with 55 AA.
